prog_ctr: RTL
=============

# prog_ctr

Program counter and fetch sequencer for the single-cycle core. Holds the current instruction address and advances it each cycle: sequentially by one, or to the absolute branch target produced by the branch-target lookup stage when a branch is taken. Also runs the Start/Done handshake with the test harness and keeps retired-instruction and taken-branch counters for performance checks.

## Interface
Parameters:
- D, 10, PC / instruction-address width; matches the lookup target width.
- START_PC, 0, address loaded on reset and on every accepted Start.
- CW, 16, width of the InstCnt and BrCnt counters.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  harness request to begin or restart a program.
- Stall  in  1  hold the PC this cycle.
- Halt  in  1  current instruction is the halt/done opcode.
- Branch  in  1  branch taken this cycle (enable and condition already resolved).
- Target  in  D  absolute branch target from the lookup stage.
- ProgCtr  out  D  current instruction address.
- Running  out  1  sequencer in RUN.
- Done  out  1  sequencer in HALT; program complete.
- InstCnt  out  CW  retired instructions since the last Start; saturating.
- BrCnt  out  CW  taken branches since the last Start; saturating.

## Operation
- States: IDLE, RUN, HALT.
- IDLE: PC holds START_PC. Start=1 -> RUN. PC stays START_PC and both counters clear on the same edge.
- RUN: each edge applies the first matching rule:
  - Stall=1 -> PC holds, counters hold. Halt and Branch are ignored.
  - Halt=1 -> HALT. PC holds, InstCnt+1.
  - Branch=1 -> PC <= Target, InstCnt+1, BrCnt+1.
  - Otherwise -> PC <= PC+1, InstCnt+1.
- RUN, Start=1: ignored. A running program cannot be restarted except by reset.
- HALT: PC and counters hold; Done=1. Start=1 -> RUN with PC <= START_PC and both counters cleared.
- Arithmetic:
  - PC+1 is modulo 2^D: 2^D-1 wraps to 0, with no flag.
  - Target is used unmodified.
  - A Target of 0 while Branch=1 is a legal jump to address 0.
- Counters saturate at 2^CW-1 and never wrap.
- Running = (state==RUN). Done = (state==HALT). Both are registered state decodes with no combinational path from inputs.

## Timing
- Reset (Reset_n low, asynchronous):
  - state=IDLE, ProgCtr=START_PC.
  - Running=0, Done=0, InstCnt=0, BrCnt=0.
  - Reset asserted mid-RUN or mid-HALT aborts immediately, with no completion.
- Start latency: Start high at edge N -> Running=1 after edge N. The first fetch is START_PC during cycle N+1.
- Branch latency: Branch/Target sampled at edge N -> ProgCtr=Target after edge N. One instruction per cycle with no bubble.
- Halt latency: Halt sampled at edge N -> Done=1 and Running=0 after edge N. ProgCtr stays at the halt instruction's address.
- Done stays high until the next accepted Start, then drops after that edge.
- Halt=1 with Branch=1 -> Halt wins.
- Stall=1 with Halt=1 -> no transition. The halt is taken on the first unstalled cycle.
- Inputs other than Start are don't-care outside RUN.

## Structure
- Shared package prog_pkg:
  - state enum (IDLE, RUN, HALT)
  - default D, START_PC and CW constants, shared with the branch-target lookup and instruction memory
- One sub-module, sat_cnt:
  - parameter CW
  - ports: clear, inc, count
  - instantiated twice, for InstCnt and BrCnt
- PC register and state machine live in prog_ctr.

## Test plan
- Reset: drop Reset_n mid-cycle with PC=57 in RUN. Required: ProgCtr=0, Running=0, Done=0 and both counters=0 immediately, without a clock edge.
- Sequential run: Start pulse, then 5 plain cycles, then Halt. Required:
  - ProgCtr steps 0,1,2,3,4,5.
  - Done=1 with ProgCtr=5, InstCnt=6, BrCnt=0.
- Branch: in RUN at PC=25, assert Branch with Target=26 and, later, with Target=89. Required:
  - PC becomes 26, then 89.
  - BrCnt increments by 1 on each branch.
  - Branch with Target=0 lands PC on 0.
- Priority and stall:
  - Stall held 3 cycles at PC=10 -> PC stays 10 and InstCnt is unchanged.
  - Halt+Branch together -> HALT, PC unchanged.
  - Stall+Halt together -> stays in RUN.
- Wrap and saturation:
  - From PC=1023 with no branch -> next PC=0.
  - With CW=4, run 20 instructions -> InstCnt stays at 15.
- Restart: Start during RUN is ignored. Start in HALT -> PC=0, counters=0, Running=1 and Done=0 after one edge.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared constants and sequencer state type for the program counter,
// branch-target lookup and instruction memory.
package prog_pkg;

    localparam int unsigned PC_W         = 10;
    localparam int unsigned START_PC_DEF = 0;
    localparam int unsigned CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: IDLE/RUN/HALT with Start/Done
// handshake, plus saturating retired-instruction and taken-branch counters.
module prog_ctr
    import prog_pkg::*;
#(
    parameter int unsigned D        = PC_W,
    parameter int unsigned START_PC = START_PC_DEF,
    parameter int unsigned CW       = CNT_W
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          Branch,
    input  logic [D-1:0]  Target,
    output logic [D-1:0]  ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] InstCnt,
    output logic [CW-1:0] BrCnt
);

    localparam logic [D-1:0] START_ADDR = D'(START_PC);

    state_e       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         cnt_clr;
    logic         inst_inc;
    logic         br_inc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Rule order in RUN: Stall, then Halt, then Branch, then sequential.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_clr  = 1'b0;
        inst_inc = 1'b0;
        br_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = START_ADDR;
                if (Start) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    inst_inc = 1'b1;
                    if (Halt) begin
                        state_d = ST_HALT;
                    end else if (Branch) begin
                        pc_d   = Target;
                        br_inc = 1'b1;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    sat_cnt #(.CW(CW)) u_inst_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (cnt_clr),
        .inc   (inst_inc),
        .count (InstCnt)
    );

    sat_cnt #(.CW(CW)) u_br_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (cnt_clr),
        .inc   (br_inc),
        .count (BrCnt)
    );

    assign ProgCtr = pc_q;
    assign Running = (state_q == ST_RUN);
    assign Done    = (state_q == ST_HALT);

endmodule
